// File: rtl/uart_prog_loader_if.sv
// Bundle between the UART byte stream, the response transmitter and program memory.
// The loader takes the slave modport; the driver/host side takes master.
interface uart_prog_loader_if #(
  parameter int DATA_BYTES = 4,
  parameter int CNT_BYTES  = 2,
  parameter int ADDR_W     = 10
);
  logic                    load_req;
  logic [7:0]              rx_data;
  logic                    rx_valid;
  logic [7:0]              tx_data;
  logic                    tx_valid;
  logic                    tx_ready;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [8*DATA_BYTES-1:0] mem_wdata;
  logic                    loading;
  logic                    load_done;
  logic                    load_err;
  logic [1:0]              err_code;
  logic [8*CNT_BYTES-1:0]  word_count;

  modport slave (
    input  load_req, rx_data, rx_valid, tx_ready,
    output tx_data, tx_valid, mem_we, mem_addr, mem_wdata,
           loading, load_done, load_err, err_code, word_count
  );

  modport master (
    output load_req, rx_data, rx_valid, tx_ready,
    input  tx_data, tx_valid, mem_we, mem_addr, mem_wdata,
           loading, load_done, load_err, err_code, word_count
  );
endinterface

// File: rtl/uart_prog_loader.sv
// UART program loader: count header, LSB-first data words written to memory,
// additive checksum, then a single ACK/NAK byte.
module uart_prog_loader #(
  parameter int         DATA_BYTES  = 4,
  parameter int         CNT_BYTES   = 2,
  parameter int         ADDR_W      = 10,
  parameter int         DEPTH       = 1024,
  parameter int         TIMEOUT_CYC = 1000000,
  parameter logic [7:0] ACK_BYTE    = 8'hA5,
  parameter logic [7:0] NAK_BYTE    = 8'h5A
) (
  input logic               CLK,
  input logic               RESET,
  uart_prog_loader_if.slave bus
);
  localparam int DW  = 8*DATA_BYTES;
  localparam int CW  = 8*CNT_BYTES;
  localparam int BIW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int CIW = (CNT_BYTES > 1) ? $clog2(CNT_BYTES) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {IDLE, CNT, DATA, CSUM, RESP, DONE, ERR} state_t;

  state_t            state;
  logic [CW-1:0]     hdr, words_rx, word_count, cnt_new;
  logic [CIW-1:0]    cnt_idx;
  logic [BIW-1:0]    byte_idx;
  logic [DW-1:0]     wbuf, wnew, mem_wdata;
  logic [7:0]        csum, tx_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [TW-1:0]     timer;
  logic [1:0]        err_code;
  logic              tx_valid, mem_we;
  logic              cnt_last, byte_last, tmo;

  // Header and word with the incoming byte dropped into its LSB-first slot.
  always_comb begin
    cnt_new = hdr;
    cnt_new[cnt_idx*8 +: 8] = bus.rx_data;
    wnew = wbuf;
    wnew[byte_idx*8 +: 8] = bus.rx_data;
  end

  assign cnt_last  = (cnt_idx == CIW'(CNT_BYTES-1));
  assign byte_last = (byte_idx == BIW'(DATA_BYTES-1));
  assign tmo       = (timer == TW'(TIMEOUT_CYC-1));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;  hdr <= '0;  words_rx <= '0;  word_count <= '0;
      cnt_idx <= '0;  byte_idx <= '0;  wbuf <= '0;  mem_wdata <= '0;
      csum <= '0;  tx_data <= '0;  mem_addr <= '0;  timer <= '0;
      err_code <= '0;  tx_valid <= 1'b0;  mem_we <= 1'b0;
    end else if (bus.load_req) begin
      state <= IDLE;  hdr <= '0;  words_rx <= '0;  word_count <= '0;
      cnt_idx <= '0;  byte_idx <= '0;  wbuf <= '0;  mem_wdata <= '0;
      csum <= '0;  tx_data <= '0;  mem_addr <= '0;  timer <= '0;
      err_code <= '0;  tx_valid <= 1'b0;  mem_we <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      // Address/count advance in the write cycle; the final address is held, never wrapped.
      if (mem_we) begin
        word_count <= word_count + 1'b1;
        if (word_count + 1'b1 != hdr) mem_addr <= mem_addr + 1'b1;
      end
      if (state == CNT || state == DATA || state == CSUM)
        timer <= bus.rx_valid ? '0 : timer + 1'b1;

      case (state)
        IDLE, CNT: begin
          if (bus.rx_valid) begin
            hdr   <= cnt_new;
            timer <= '0;
            if (!cnt_last) begin
              cnt_idx <= cnt_idx + 1'b1;
              state   <= CNT;
            end else if (cnt_new == '0) begin
              tx_data <= ACK_BYTE;  tx_valid <= 1'b1;  state <= RESP;
            end else if (32'(cnt_new) > DEPTH) begin
              err_code <= 2'd2;
              tx_data <= NAK_BYTE;  tx_valid <= 1'b1;  state <= RESP;
            end else begin
              mem_addr <= '0;  csum <= '0;  byte_idx <= '0;
              words_rx <= '0;  word_count <= '0;
              state    <= DATA;
            end
          end else if (state == CNT && tmo) begin
            err_code <= 2'd3;
            tx_data <= NAK_BYTE;  tx_valid <= 1'b1;  state <= RESP;
          end
        end
        DATA: begin
          if (bus.rx_valid) begin
            wbuf <= wnew;
            csum <= csum + bus.rx_data;
            if (byte_last) begin
              byte_idx  <= '0;
              mem_we    <= 1'b1;
              mem_wdata <= wnew;
              words_rx  <= words_rx + 1'b1;
              if (words_rx + 1'b1 == hdr) state <= CSUM;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end else if (tmo) begin
            err_code <= 2'd3;
            tx_data <= NAK_BYTE;  tx_valid <= 1'b1;  state <= RESP;
          end
        end
        CSUM: begin
          if (bus.rx_valid) begin
            if (bus.rx_data == csum) begin
              tx_data <= ACK_BYTE;
            end else begin
              err_code <= 2'd1;
              tx_data  <= NAK_BYTE;
            end
            tx_valid <= 1'b1;
            state    <= RESP;
          end else if (tmo) begin
            err_code <= 2'd3;
            tx_data <= NAK_BYTE;  tx_valid <= 1'b1;  state <= RESP;
          end
        end
        RESP: begin
          // Any NAK path has already set a nonzero err_code.
          if (bus.tx_ready) begin
            tx_valid <= 1'b0;
            state    <= (err_code == 2'd0) ? DONE : ERR;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.tx_data    = tx_data;
  assign bus.tx_valid   = tx_valid;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;
  assign bus.err_code   = err_code;
  assign bus.word_count = word_count;
  assign bus.loading    = (state == CNT) || (state == DATA) || (state == CSUM);
  assign bus.load_done  = (state == DONE);
  assign bus.load_err   = (state == ERR);
endmodule
